// File: rtl/lock_qualifier.sv
// lock_qualifier: resynchronises the clock-manager LOCKED signal, qualifies
// it over a stable window before raising IRDY, filters short unlock glitches,
// re-pulses DCM_RST on lock loss or lock timeout, and keeps sticky status.
//
// Handshake: none. IRDY is a level qualified ready. DCM_RST is a level reset
// to the clock manager. CLR_STATUS is a single-cycle clear sampled on the
// clock edge. A LOCK_LOST set on the same edge as CLR_STATUS takes priority.
module lock_qualifier #(
  parameter int CNT_W         = 16,
  parameter int RST_PULSE     = 4,
  parameter int LOCK_STABLE   = 8,
  parameter int UNLOCK_FILTER = 3,
  parameter int LOCK_TIMEOUT  = 1000
) (
  input  logic       CLK_generic,
  input  logic       RST_N,
  input  logic       LOCKED_RAW,
  input  logic       CLR_STATUS,
  output logic       IRDY,
  output logic       DCM_RST,
  output logic       LOCK_LOST,
  output logic [3:0] RETRY_COUNT
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_WAIT  = 2'd1,
    S_QUAL  = 2'd2,
    S_READY = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO      = '0;
  localparam logic [CNT_W-1:0] PULSE_C   = CNT_W'(RST_PULSE);
  localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(LOCK_STABLE);
  localparam logic [CNT_W-1:0] UNLOCK_C  = CNT_W'(UNLOCK_FILTER);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(LOCK_TIMEOUT);

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] tout_q, tout_d;
  logic [CNT_W-1:0] qual_q, qual_d;
  logic [CNT_W-1:0] unlock_q, unlock_d;
  logic             irdy_q, irdy_d;
  logic             dcm_rst_q, dcm_rst_d;
  logic             lock_lost_q, lock_lost_d;
  logic [3:0]       retry_q, retry_d;

  logic             lock_s;
  logic [CNT_W-1:0] pulse_inc, tout_inc, qual_inc, unlock_inc;
  logic             go_ready, go_retry, go_lost, go_reset;

  assign lock_s = sync2_q;

  // Two-flop synchroniser for the asynchronous LOCKED input.
  always_ff @(posedge CLK_generic or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= LOCKED_RAW;
      sync2_q <= sync1_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK_generic or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_RESET;
      pulse_q     <= '0;
      tout_q      <= '0;
      qual_q      <= '0;
      unlock_q    <= '0;
      irdy_q      <= 1'b0;
      dcm_rst_q   <= 1'b1;
      lock_lost_q <= 1'b0;
      retry_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      tout_q      <= tout_d;
      qual_q      <= qual_d;
      unlock_q    <= unlock_d;
      irdy_q      <= irdy_d;
      dcm_rst_q   <= dcm_rst_d;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
    end
  end

  // Next-state logic; ready beats timeout when both land on the same edge.
  always_comb begin
    state_d    = state_q;
    pulse_d    = pulse_q;
    tout_d     = tout_q;
    qual_d     = qual_q;
    unlock_d   = unlock_q;
    retry_d    = retry_q;
    pulse_inc  = pulse_q + ONE;
    tout_inc   = tout_q + ONE;
    qual_inc   = qual_q + ONE;
    unlock_inc = unlock_q + ONE;
    go_ready   = 1'b0;
    go_retry   = 1'b0;
    go_lost    = 1'b0;
    go_reset   = 1'b0;

    case (state_q)
      S_RESET: begin
        pulse_d = pulse_inc;
        if (pulse_inc == PULSE_C) begin
          state_d  = S_WAIT;
          pulse_d  = ZERO;
          tout_d   = ZERO;
          qual_d   = ZERO;
          unlock_d = ZERO;
        end
      end
      S_WAIT: begin
        tout_d = tout_inc;
        if (lock_s && (STABLE_C == ONE)) begin
          go_ready = 1'b1;
        end else if (tout_inc == TIMEOUT_C) begin
          go_retry = 1'b1;
        end else if (lock_s) begin
          state_d = S_QUAL;
          qual_d  = ONE;
        end
      end
      S_QUAL: begin
        tout_d = tout_inc;
        if (lock_s && (qual_inc == STABLE_C)) begin
          go_ready = 1'b1;
        end else if (tout_inc == TIMEOUT_C) begin
          go_retry = 1'b1;
        end else if (lock_s) begin
          qual_d = qual_inc;
        end else begin
          state_d = S_WAIT;
          qual_d  = ZERO;
        end
      end
      S_READY: begin
        if (!lock_s) begin
          unlock_d = unlock_inc;
          if (unlock_inc == UNLOCK_C) begin
            go_lost = 1'b1;
          end
        end else begin
          unlock_d = ZERO;
        end
      end
      default: begin
        go_reset = 1'b1;
      end
    endcase

    if (go_ready) begin
      state_d  = S_READY;
      qual_d   = ZERO;
      tout_d   = ZERO;
      unlock_d = ZERO;
    end

    if (go_retry || go_lost || go_reset) begin
      state_d  = S_RESET;
      pulse_d  = ZERO;
      tout_d   = ZERO;
      qual_d   = ZERO;
      unlock_d = ZERO;
    end

    if (go_retry && (retry_q != 4'hF)) begin
      retry_d = retry_q + 4'd1;
    end
  end

  // Registered outputs follow the next state; a new loss overrides a clear.
  always_comb begin
    irdy_d      = (state_d == S_READY);
    dcm_rst_d   = (state_d == S_RESET);
    lock_lost_d = go_lost | (lock_lost_q & ~CLR_STATUS);
  end

  assign IRDY        = irdy_q;
  assign DCM_RST     = dcm_rst_q;
  assign LOCK_LOST   = lock_lost_q;
  assign RETRY_COUNT = retry_q;

endmodule

// File: tb/tb_lock_qualifier.sv
// Directed bench for lock_qualifier with a short lock timeout.
module tb_lock_qualifier;

  logic       clk;
  logic       rst_n;
  logic       locked_raw;
  logic       clr_status;
  logic       irdy;
  logic       dcm_rst;
  logic       lock_lost;
  logic [3:0] retry_count;

  int n_cmp;
  int n_fail;

  lock_qualifier #(
    .CNT_W        (16),
    .RST_PULSE    (4),
    .LOCK_STABLE  (8),
    .UNLOCK_FILTER(3),
    .LOCK_TIMEOUT (40)
  ) dut (
    .CLK_generic(clk),
    .RST_N      (rst_n),
    .LOCKED_RAW (locked_raw),
    .CLR_STATUS (clr_status),
    .IRDY       (irdy),
    .DCM_RST    (dcm_rst),
    .LOCK_LOST  (lock_lost),
    .RETRY_COUNT(retry_count)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One active edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and run the 4-edge DCM_RST pulse so the DUT sits in S_WAIT.
  task automatic reset_to_wait();
    rst_n      = 1'b0;
    locked_raw = 1'b0;
    clr_status = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (irdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_irdy: got %b expected 0", irdy);
    end
    n_cmp++;
    if (dcm_rst !== 1'b1) begin
      n_fail++; $display("FAIL reset_dcm_rst: got %b expected 1", dcm_rst);
    end
    n_cmp++;
    if (lock_lost !== 1'b0) begin
      n_fail++; $display("FAIL reset_lock_lost: got %b expected 0", lock_lost);
    end
    n_cmp++;
    if (retry_count !== 4'd0) begin
      n_fail++; $display("FAIL reset_retry: got %0d expected 0", retry_count);
    end
  endtask

  // Edges 1..3 keep DCM_RST high, edge 4 drops it.
  task automatic test_pulse();
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      n_cmp++;
      if (dcm_rst !== 1'b1 || irdy !== 1'b0) begin
        n_fail++; $display("FAIL pulse_edge%0d: got dcm=%b irdy=%b expected dcm=1 irdy=0", e, dcm_rst, irdy);
      end
    end
    step();
    n_cmp++;
    if (dcm_rst !== 1'b0 || irdy !== 1'b0) begin
      n_fail++; $display("FAIL pulse_end: got dcm=%b irdy=%b expected dcm=0 irdy=0", dcm_rst, irdy);
    end
  endtask

  // Raw high first sampled at edge 5 -> IRDY after edge 14.
  task automatic test_lock();
    locked_raw = 1'b1;
    for (int e = 5; e <= 13; e++) begin
      step();
      n_cmp++;
      if (irdy !== 1'b0) begin
        n_fail++; $display("FAIL lock_early_edge%0d: got irdy=%b expected 0", e, irdy);
      end
    end
    step();
    n_cmp++;
    if (irdy !== 1'b1 || dcm_rst !== 1'b0) begin
      n_fail++; $display("FAIL lock_ready: got irdy=%b dcm=%b expected irdy=1 dcm=0", irdy, dcm_rst);
    end
    n_cmp++;
    if (lock_lost !== 1'b0 || retry_count !== 4'd0) begin
      n_fail++; $display("FAIL lock_status: got lost=%b retry=%0d expected lost=0 retry=0", lock_lost, retry_count);
    end
  endtask

  // Two-cycle low glitch while ready must not drop IRDY.
  task automatic test_glitch();
    locked_raw = 1'b0;
    step();
    step();
    locked_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (irdy !== 1'b1 || dcm_rst !== 1'b0) begin
        n_fail++; $display("FAIL glitch_cycle%0d: got irdy=%b dcm=%b expected irdy=1 dcm=0", i, irdy, dcm_rst);
      end
    end
  endtask

  // Sustained low first sampled at edge j drops IRDY after edge j+4.
  task automatic test_loss();
    locked_raw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (irdy !== 1'b1) begin
        n_fail++; $display("FAIL loss_early%0d: got irdy=%b expected 1", i, irdy);
      end
    end
    step();
    n_cmp++;
    if (irdy !== 1'b0 || dcm_rst !== 1'b1) begin
      n_fail++; $display("FAIL loss_drop: got irdy=%b dcm=%b expected irdy=0 dcm=1", irdy, dcm_rst);
    end
    n_cmp++;
    if (lock_lost !== 1'b1 || retry_count !== 4'd0) begin
      n_fail++; $display("FAIL loss_status: got lost=%b retry=%0d expected lost=1 retry=0", lock_lost, retry_count);
    end
  endtask

  task automatic test_clr();
    step();
    n_cmp++;
    if (lock_lost !== 1'b1) begin
      n_fail++; $display("FAIL clr_sticky: got lost=%b expected 1", lock_lost);
    end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    n_cmp++;
    if (lock_lost !== 1'b0) begin
      n_fail++; $display("FAIL clr_clear: got lost=%b expected 0", lock_lost);
    end
  endtask

  // Raw high sampled at edges 5..9, low at 10, high again from 11 -> IRDY after edge 20.
  task automatic test_qual_restart();
    reset_to_wait();
    locked_raw = 1'b1;
    for (int e = 5; e <= 19; e++) begin
      if (e == 10) locked_raw = 1'b0;
      if (e == 11) locked_raw = 1'b1;
      step();
      n_cmp++;
      if (irdy !== 1'b0) begin
        n_fail++; $display("FAIL qual_early_edge%0d: got irdy=%b expected 0", e, irdy);
      end
    end
    step();
    n_cmp++;
    if (irdy !== 1'b1) begin
      n_fail++; $display("FAIL qual_restart_ready: got irdy=%b expected 1", irdy);
    end
  endtask

  // With no lock, retry n lands on edge 44*n; count saturates at 15.
  task automatic test_retry();
    int exp_r;
    reset_to_wait();
    for (int e = 5; e <= 43; e++) step();
    n_cmp++;
    if (retry_count !== 4'd0 || dcm_rst !== 1'b0) begin
      n_fail++; $display("FAIL retry_pre: got retry=%0d dcm=%b expected retry=0 dcm=0", retry_count, dcm_rst);
    end
    step();
    n_cmp++;
    if (retry_count !== 4'd1 || dcm_rst !== 1'b1) begin
      n_fail++; $display("FAIL retry_first: got retry=%0d dcm=%b expected retry=1 dcm=1", retry_count, dcm_rst);
    end
    for (int e = 45; e <= 47; e++) step();
    n_cmp++;
    if (dcm_rst !== 1'b1) begin
      n_fail++; $display("FAIL retry_pulse_hold: got dcm=%b expected 1", dcm_rst);
    end
    step();
    n_cmp++;
    if (dcm_rst !== 1'b0) begin
      n_fail++; $display("FAIL retry_pulse_end: got dcm=%b expected 0", dcm_rst);
    end
    for (int e = 49; e <= 87; e++) step();
    n_cmp++;
    if (retry_count !== 4'd1) begin
      n_fail++; $display("FAIL retry_hold: got retry=%0d expected 1", retry_count);
    end
    step();
    n_cmp++;
    if (retry_count !== 4'd2) begin
      n_fail++; $display("FAIL retry_second: got retry=%0d expected 2", retry_count);
    end
    for (int n = 3; n <= 17; n++) begin
      for (int i = 0; i < 44; i++) step();
      exp_r = (n > 15) ? 15 : n;
      n_cmp++;
      if (retry_count !== 4'(exp_r) || dcm_rst !== 1'b1 || irdy !== 1'b0) begin
        n_fail++; $display("FAIL retry_n%0d: got retry=%0d dcm=%b irdy=%b expected retry=%0d dcm=1 irdy=0",
                           n, retry_count, dcm_rst, irdy, exp_r);
      end
    end
  endtask

  // Continues from a fresh retry at edge 748: ready at 760, loss with clear at 765.
  task automatic test_loss_clr_same_edge();
    locked_raw = 1'b1;
    for (int i = 0; i < 11; i++) step();
    n_cmp++;
    if (irdy !== 1'b0) begin
      n_fail++; $display("FAIL same_pre_ready: got irdy=%b expected 0", irdy);
    end
    step();
    n_cmp++;
    if (irdy !== 1'b1) begin
      n_fail++; $display("FAIL same_ready: got irdy=%b expected 1", irdy);
    end
    locked_raw = 1'b0;
    for (int i = 0; i < 4; i++) step();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    n_cmp++;
    if (lock_lost !== 1'b1 || irdy !== 1'b0 || dcm_rst !== 1'b1) begin
      n_fail++; $display("FAIL same_edge_set_wins: got lost=%b irdy=%b dcm=%b expected lost=1 irdy=0 dcm=1",
                         lock_lost, irdy, dcm_rst);
    end
    n_cmp++;
    if (retry_count !== 4'd15) begin
      n_fail++; $display("FAIL same_retry_kept: got retry=%0d expected 15", retry_count);
    end
  endtask

  // Into S_QUAL with sticky status set, then pull reset between edges.
  task automatic test_async_reset();
    locked_raw = 1'b1;
    for (int i = 0; i < 6; i++) step();
    n_cmp++;
    if (dcm_rst !== 1'b0 || irdy !== 1'b0 || lock_lost !== 1'b1) begin
      n_fail++; $display("FAIL async_pre: got dcm=%b irdy=%b lost=%b expected dcm=0 irdy=0 lost=1",
                         dcm_rst, irdy, lock_lost);
    end
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (irdy !== 1'b0 || dcm_rst !== 1'b1) begin
      n_fail++; $display("FAIL async_outputs: got irdy=%b dcm=%b expected irdy=0 dcm=1", irdy, dcm_rst);
    end
    n_cmp++;
    if (lock_lost !== 1'b0 || retry_count !== 4'd0) begin
      n_fail++; $display("FAIL async_status: got lost=%b retry=%0d expected lost=0 retry=0", lock_lost, retry_count);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    locked_raw = 1'b0;
    clr_status = 1'b0;
    step();
    step();
    test_reset();
    test_pulse();
    test_lock();
    test_glitch();
    test_loss();
    test_clr();
    test_qual_restart();
    test_retry();
    test_loss_clr_same_edge();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
